// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the sequenced RAM controller.
// State encoding is fixed here so benches and tools agree on it.
package ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SETUP = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        RD_EN    = 3'd4,
        RD_CAP   = 3'd5,
        RSP      = 3'd6
    } state_t;

endpackage

// File: rtl/ram_seq_ctrl.sv
// Sequencer for an async-strobe RAM: setup/pulse/hold writes, two-cycle reads.
// Define RAM_SEQ_CTRL_VERIFY_EN to read back each write and flag mismatches.
module ram_seq_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dataout
);

    state_t state;
    state_t next;
    logic   accept;

`ifdef RAM_SEQ_CTRL_VERIFY_EN
    logic wr_q;
    logic err_q;

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        next   = state;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    next   = req_wr ? WR_SETUP : RD_EN;
                end
            end
            WR_SETUP: next = WR_PULSE;
            WR_PULSE: next = WR_HOLD;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
            WR_HOLD:  next = RD_EN;
`else
            WR_HOLD:  next = RSP;
`endif
            RD_EN:    next = RD_CAP;
            RD_CAP:   next = RSP;
            RSP:      next = IDLE;
            default:  next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Strobes are decoded from next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            ram_addr   <= '0;
            ram_datain <= '0;
            ram_read   <= 1'b0;
            ram_write  <= 1'b0;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            req_ready <= (next == IDLE);
            rsp_valid <= (next == RSP);
            ram_write <= (next == WR_PULSE);
            ram_read  <= (next == RD_EN) || (next == RD_CAP);
            if (accept) begin
                ram_addr   <= req_addr;
                ram_datain <= req_wr ? req_wdata : '0;
                rsp_rdata  <= '0;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
                wr_q       <= req_wr;
                err_q      <= 1'b0;
`endif
            end
            if (state == RD_CAP) begin
                rsp_rdata <= ram_dataout;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
                err_q     <= wr_q && (ram_dataout != ram_datain);
`endif
            end
        end
    end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl with a behavioural async-strobe RAM and reference memory.
// RAM initial image is init_val(addr) = (3*addr + 1) mod 16.
`timescale 1ns/1ps
module tb_ram_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [3:0] req_wdata;
    logic       rsp_valid;
    logic [3:0] rsp_rdata;
    logic       rsp_err;
    logic [3:0] ram_addr;
    logic [3:0] ram_datain;
    logic       ram_read;
    logic       ram_write;
    wire  [3:0] ram_dataout;
    logic       force_zero = 1'b0;

    logic [3:0] mem [16];
    logic [3:0] exp_mem [16];

    int checks = 0;
    int errors = 0;

`ifdef RAM_SEQ_CTRL_VERIFY_EN
    localparam int  WR_LAT   = 6;
    localparam int  WR_RDCYC = 2;
    localparam bit  VERIFY   = 1'b1;
`else
    localparam int  WR_LAT   = 4;
    localparam int  WR_RDCYC = 0;
    localparam bit  VERIFY   = 1'b0;
`endif
    localparam int RD_LAT = 3;

    always #5 clk = ~clk;

    ram_seq_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_addr   (ram_addr),
        .ram_datain (ram_datain),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .ram_dataout(ram_dataout)
    );

    function automatic logic [3:0] init_val(input int i);
        int v;
        v = (i * 3 + 1) % 16;
        return 4'(v);
    endfunction

    // RAM model: writes on rising ram_write, output high-Z unless read enabled.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = init_val(i);
        forever begin
            @(posedge ram_write);
            mem[ram_addr] = ram_datain;
        end
    end

    assign ram_dataout = force_zero ? 4'h0 : (ram_read ? mem[ram_addr] : 4'bz);

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, simulation stuck");
        $fatal(1);
    end

    task automatic do_req(input logic wr, input logic [3:0] a, input logic [3:0] d,
                          output logic [3:0] rdata, output logic err, output int lat,
                          output int wp, output int rc, output int bad, output logic one);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wp = 0; rc = 0; bad = 0;
        rdata = 4'hx; err = 1'bx;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (ram_write === 1'b1) wp++;
            if (ram_read === 1'b1) rc++;
            if (ram_write === 1'b1 && ram_read === 1'b1) bad++;
            if (ram_addr !== a) bad++;
            if (wr && ram_datain !== d) bad++;
            if (rsp_valid === 1'b1) begin
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
        @(negedge clk);
        one = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_err, ram_read, ram_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got v%b e%b r%b w%b want 0",
                     rsp_valid, rsp_err, ram_read, ram_write);
        end
        checks++;
        if ({rsp_rdata, ram_addr, ram_datain} !== 12'h000) begin
            errors++;
            $display("FAIL reset_data: got rd%h a%h di%h want 0", rsp_rdata, ram_addr, ram_datain);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [3:0] rd; logic er; int lat, wp, rc, bad; logic one;
        do_req(1'b1, 4'h3, 4'hA, rd, er, lat, wp, rc, bad, one);
        exp_mem[3] = 4'hA;
        checks++;
        if (lat !== WR_LAT) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat, WR_LAT); end
        checks++;
        if (wp !== 1) begin errors++; $display("FAIL wr_pulse_count: got %0d want 1", wp); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wr_addr_data_stable: got %0d bad cycles want 0", bad); end
        checks++;
        if (rc !== WR_RDCYC) begin errors++; $display("FAIL wr_read_cycles: got %0d want %0d", rc, WR_RDCYC); end
        checks++;
        if (rd !== (VERIFY ? 4'hA : 4'h0) || er !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: got rd %h err %b want %h 0", rd, er, VERIFY ? 4'hA : 4'h0);
        end
        checks++;
        if (!one) begin errors++; $display("FAIL wr_rsp_single: got extra pulse/not ready, want one pulse"); end
        checks++;
        if (mem[3] !== 4'hA) begin errors++; $display("FAIL ram_content_3: got %h want a", mem[3]); end
        do_req(1'b0, 4'h3, 4'h0, rd, er, lat, wp, rc, bad, one);
        checks++;
        if (lat !== RD_LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat, RD_LAT); end
        checks++;
        if (rc !== 2 || wp !== 0) begin errors++; $display("FAIL rd_strobes: got rd %0d wr %0d want 2 0", rc, wp); end
        checks++;
        if (rd !== exp_mem[3] || er !== 1'b0) begin
            errors++; $display("FAIL rd_data_3: got %h err %b want %h 0", rd, er, exp_mem[3]);
        end
    endtask

    task automatic test_unwritten();
        logic [3:0] rd; logic er; int lat, wp, rc, bad; logic one;
        do_req(1'b0, 4'hE, 4'h0, rd, er, lat, wp, rc, bad, one);
        checks++;
        if (rd !== init_val(14)) begin errors++; $display("FAIL rd_unwritten_e: got %h want %h", rd, init_val(14)); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rd_addr_e: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        int acc, rsps, wps, busy_ready, cyc;
        logic ready_s;
        logic [3:0] rd; logic er; int lat, wp, rc, bad; logic one;
        acc = 0; rsps = 0; wps = 0; busy_ready = 0; cyc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'h0; req_wdata = 4'h5;
        while (rsps < 3 && cyc < 60) begin
            ready_s = req_ready;
            if (rsp_valid === 1'b1) rsps++;
            if (ram_write === 1'b1) wps++;
            if (ready_s === 1'b1 && acc > rsps) busy_ready++;
            @(posedge clk);
            if (ready_s === 1'b1 && req_valid) begin
                acc++;
                #1;
                if (acc < 3) begin
                    req_addr = 4'(acc); req_wdata = 4'(5 + acc);
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) exp_mem[i] = 4'(5 + i);
        checks++;
        if (acc !== 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        checks++;
        if (rsps !== 3) begin errors++; $display("FAIL b2b_rsps: got %0d want 3", rsps); end
        checks++;
        if (wps !== 3) begin errors++; $display("FAIL b2b_wr_pulses: got %0d want 3", wps); end
        checks++;
        if (busy_ready !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d cycles want 0", busy_ready); end
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 4'(i), 4'h0, rd, er, lat, wp, rc, bad, one);
            checks++;
            if (rd !== exp_mem[i]) begin errors++; $display("FAIL b2b_readback_%0d: got %h want %h", i, rd, exp_mem[i]); end
        end
    endtask

    task automatic test_reset_mid_op();
        int wps, rsps;
        logic [3:0] rd; logic er; int lat, wp, rc, bad; logic one;
        wps = 0; rsps = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'h7; req_wdata = 4'h9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (ram_write === 1'b1) wps++;
        rst = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || {rsp_valid, rsp_err, ram_read, ram_write} !== 4'b0000 ||
            {rsp_rdata, ram_addr, ram_datain} !== 12'h000) begin
            errors++;
            $display("FAIL midrst_outputs: got rdy%b v%b e%b r%b w%b rd%h a%h di%h want 1 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, ram_read, ram_write, rsp_rdata, ram_addr, ram_datain);
        end
        repeat (2) begin
            @(negedge clk);
            if (ram_write === 1'b1) wps++;
            if (rsp_valid === 1'b1) rsps++;
        end
        rst = 1'b0; req_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ram_write === 1'b1) wps++;
            if (rsp_valid === 1'b1) rsps++;
        end
        checks++;
        if (wps !== 0 || rsps !== 0) begin
            errors++; $display("FAIL midrst_activity: got wr %0d rsp %0d want 0 0", wps, rsps);
        end
        checks++;
        if (mem[7] !== exp_mem[7]) begin errors++; $display("FAIL midrst_ram7: got %h want %h", mem[7], exp_mem[7]); end
        do_req(1'b0, 4'h7, 4'h0, rd, er, lat, wp, rc, bad, one);
        checks++;
        if (rd !== exp_mem[7]) begin errors++; $display("FAIL midrst_read7: got %h want %h", rd, exp_mem[7]); end
    endtask

`ifdef RAM_SEQ_CTRL_VERIFY_EN
    task automatic test_verify();
        logic [3:0] rd; logic er; int lat, wp, rc, bad; logic one;
        force_zero = 1'b1;
        do_req(1'b1, 4'hF, 4'hF, rd, er, lat, wp, rc, bad, one);
        force_zero = 1'b0;
        exp_mem[15] = 4'hF;
        checks++;
        if (er !== 1'b1 || rd !== 4'h0) begin
            errors++; $display("FAIL verify_forced: got err %b rd %h want 1 0", er, rd);
        end
        checks++;
        if (lat !== WR_LAT) begin errors++; $display("FAIL verify_latency: got %0d want %0d", lat, WR_LAT); end
        do_req(1'b1, 4'hF, 4'hF, rd, er, lat, wp, rc, bad, one);
        checks++;
        if (er !== 1'b0 || rd !== 4'hF) begin
            errors++; $display("FAIL verify_clean: got err %b rd %h want 0 f", er, rd);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] rd; logic er; int lat, wp, rc, bad; logic one;
        logic wr; logic [3:0] a, d, exp_rd;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            do_req(wr, a, d, rd, er, lat, wp, rc, bad, one);
            if (wr) begin
                exp_mem[a] = d;
                exp_rd = VERIFY ? d : 4'h0;
            end else begin
                exp_rd = exp_mem[a];
            end
            checks++;
            if (rd !== exp_rd || er !== 1'b0) begin
                errors++; $display("FAIL rand_rsp_%0d: got rd %h err %b want %h 0", n, rd, er, exp_rd);
            end
            checks++;
            if (lat !== (wr ? WR_LAT : RD_LAT)) begin
                errors++; $display("FAIL rand_latency_%0d: got %0d want %0d", n, lat, wr ? WR_LAT : RD_LAT);
            end
            checks++;
            if (wp !== (wr ? 1 : 0) || rc !== (wr ? WR_RDCYC : 2)) begin
                errors++; $display("FAIL rand_strobes_%0d: got wr %0d rd %0d", n, wp, rc);
            end
            checks++;
            if (bad !== 0 || !one) begin
                errors++; $display("FAIL rand_protocol_%0d: got bad %0d single %b want 0 1", n, bad, one);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
        test_reset();
        test_write_read();
        test_unwritten();
        test_back_to_back();
        test_reset_mid_op();
`ifdef RAM_SEQ_CTRL_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
